issue_scoreboard: RTL and testbench

- Parametrised in-order issue / out-of-order write-back / in-order commit scoreboard, sitting between the ID stage and the EX/commit stages.
- Successor of the fixed 4-entry, 3-write-back-port scoreboard. Depth and write-back port count are now parameters.
- Adds same-cycle multi-port write-back, flush, and a two-operand pending/forwarding lookup for the issue stage.
- Entries are scoreboard_entry; an entry's trans_id is its buffer slot index.

---
 rtl/issue_scoreboard_pkg.sv | 31 +++
 rtl/issue_scoreboard_lookup.sv | 37 +++
 rtl/issue_scoreboard.sv | 133 +++++++++++++
 tb/tb_issue_scoreboard.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared types and default sizing for the issue scoreboard.
package issue_scoreboard_pkg;

  localparam int NR_SB_ENTRIES = 8;
  localparam int NR_WB_PORTS   = 4;
  localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef enum logic [2:0] {
    FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_MULT, FU_CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  // result carries the immediate at issue and the FU result after write-back
  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [7:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    exception                 ex;
  } scoreboard_entry;

endpackage

// File: rtl/issue_scoreboard_lookup.sv
// Youngest-producer finder for one source operand. Walks the ring from head
// (oldest) towards tail; a later match overrides an earlier one, so the last
// hit is the youngest issued writer of rs.
module sb_operand_lookup #(
  parameter  int NR_ENTRIES = 8,
  localparam int TID_W      = $clog2(NR_ENTRIES)
) (
  input  logic [4:0]                        rs_i,
  input  logic [TID_W-1:0]                  head_i,
  input  logic [NR_ENTRIES-1:0]             issued_i,
  input  logic [NR_ENTRIES-1:0]             valid_i,
  input  logic [NR_ENTRIES-1:0][4:0]        rd_i,
  input  logic [NR_ENTRIES-1:0][63:0]       result_i,
  output logic                              pending_o,
  output logic                              valid_o,
  output logic [63:0]                       data_o
);

  logic [TID_W-1:0] idx;

  // age-ordered scan, youngest match wins; x0 never has a producer
  always_comb begin
    pending_o = 1'b0;
    valid_o   = 1'b0;
    data_o    = '0;
    idx       = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      idx = head_i + TID_W'(i);
      if (rs_i != 5'd0 && issued_i[idx] && rd_i[idx] == rs_i) begin
        pending_o = 1'b1;
        valid_o   = valid_i[idx];
        data_o    = result_i[idx];
      end
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue, out-of-order write-back, in-order commit scoreboard.
// trans_id of an entry is its slot index in the ring buffer.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter  int NR_ENTRIES  = NR_SB_ENTRIES,
  parameter  int NR_WB_PORTS = issue_scoreboard_pkg::NR_WB_PORTS,
  localparam int TID_W       = $clog2(NR_ENTRIES)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                issue_valid_i,
  output logic                                issue_ready_o,
  input  scoreboard_entry                     issue_instr_i,
  output logic [TID_W-1:0]                    issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]              wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TID_W-1:0]   wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]        wb_result_i,
  input  exception [NR_WB_PORTS-1:0]          wb_ex_i,
  output logic                                commit_valid_o,
  output scoreboard_entry                     commit_instr_o,
  input  logic                                commit_ack_i,
  input  logic [4:0]                          rs1_i,
  input  logic [4:0]                          rs2_i,
  output logic                                rs1_pending_o,
  output logic                                rs2_pending_o,
  output logic                                rs1_valid_o,
  output logic                                rs2_valid_o,
  output logic [63:0]                         rs1_o,
  output logic [63:0]                         rs2_o
);

  scoreboard_entry [NR_ENTRIES-1:0] mem_q, mem_d;
  logic [NR_ENTRIES-1:0]            issued_q, issued_d;
  logic [TID_W-1:0]                 head_q, head_d, tail_q, tail_d;
  logic [TID_W:0]                   cnt_q, cnt_d;
  logic                             issue_fire, commit_fire;

  assign issue_ready_o    = (cnt_q != (TID_W+1)'(NR_ENTRIES));
  assign issue_trans_id_o = tail_q;
  assign commit_instr_o   = mem_q[head_q];
  assign commit_valid_o   = (cnt_q != '0) && mem_q[head_q].valid;
  assign issue_fire       = issue_valid_i && issue_ready_o;
  assign commit_fire      = commit_ack_i && commit_valid_o;

  // next state: issue, then write-back (highest port last), then commit, flush overrides all
  always_comb begin
    mem_d    = mem_q;
    issued_d = issued_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;

    if (issue_fire) begin
      mem_d[tail_q]          = issue_instr_i;
      mem_d[tail_q].trans_id = TRANS_ID_BITS'(tail_q);
      mem_d[tail_q].valid    = 1'b0;
      issued_d[tail_q]       = 1'b1;
      tail_d                 = tail_q + 1'b1;
    end

    // gated by registered issued bits, so a write-back never lands on a slot
    // being issued in the same cycle
    for (int k = 0; k < NR_WB_PORTS; k++) begin
      if (wb_valid_i[k] && issued_q[wb_trans_id_i[k]]) begin
        mem_d[wb_trans_id_i[k]].result = wb_result_i[k];
        mem_d[wb_trans_id_i[k]].valid  = 1'b1;
        if (wb_ex_i[k].valid) mem_d[wb_trans_id_i[k]].ex = wb_ex_i[k];
      end
    end

    if (commit_fire) begin
      issued_d[head_q]    = 1'b0;
      mem_d[head_q].valid = 1'b0;
      head_d              = head_q + 1'b1;
    end

    case ({issue_fire, commit_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (flush_i) begin
      head_d   = '0;
      tail_d   = '0;
      cnt_d    = '0;
      issued_d = '0;
      for (int i = 0; i < NR_ENTRIES; i++) mem_d[i].valid = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      issued_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      issued_q <= issued_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
    end
  end

  logic [NR_ENTRIES-1:0]       valid_vec;
  logic [NR_ENTRIES-1:0][4:0]  rd_vec;
  logic [NR_ENTRIES-1:0][63:0] res_vec;

  for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_vec
    assign valid_vec[g] = mem_q[g].valid;
    assign rd_vec[g]    = mem_q[g].rd;
    assign res_vec[g]   = mem_q[g].result;
  end

  sb_operand_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_rs1 (
    .rs_i(rs1_i), .head_i(head_q), .issued_i(issued_q), .valid_i(valid_vec),
    .rd_i(rd_vec), .result_i(res_vec),
    .pending_o(rs1_pending_o), .valid_o(rs1_valid_o), .data_o(rs1_o)
  );

  sb_operand_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_rs2 (
    .rs_i(rs2_i), .head_i(head_q), .issued_i(issued_q), .valid_i(valid_vec),
    .rd_i(rd_vec), .result_i(res_vec),
    .pending_o(rs2_pending_o), .valid_o(rs2_valid_o), .data_o(rs2_o)
  );

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: in-order commit scoreboard queue, operand
// lookup vector table, and hand sequences for full/wrap/flush corners.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  flush_i;
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  scoreboard_entry       issue_instr_i;
  logic [2:0]            issue_trans_id_o;
  logic [3:0]            wb_valid_i;
  logic [3:0][2:0]       wb_trans_id_i;
  logic [3:0][63:0]      wb_result_i;
  exception [3:0]        wb_ex_i;
  logic                  commit_valid_o;
  scoreboard_entry       commit_instr_o;
  logic                  commit_ack_i;
  logic [4:0]            rs1_i, rs2_i;
  logic                  rs1_pending_o, rs2_pending_o, rs1_valid_o, rs2_valid_o;
  logic [63:0]           rs1_o, rs2_o;

  issue_scoreboard dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_trans_id_o(issue_trans_id_o),
    .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i),
    .wb_result_i(wb_result_i), .wb_ex_i(wb_ex_i),
    .commit_valid_o(commit_valid_o), .commit_instr_o(commit_instr_o),
    .commit_ack_i(commit_ack_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rs1_pending_o(rs1_pending_o), .rs2_pending_o(rs2_pending_o),
    .rs1_valid_o(rs1_valid_o), .rs2_valid_o(rs2_valid_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [2:0] tid; logic [4:0] rd; } exp_t;
  exp_t        sbq[$];
  logic [63:0] exp_res [8];
  logic [2:0]  m_tail;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic iv; logic [4:0] rd; logic [63:0] imm;
    logic wv; logic [2:0] wid; logic [63:0] wd;
    logic [4:0] rs1; logic [4:0] rs2;
    logic p1; logic v1; logic [63:0] d1;
    logic p2; logic v2; logic [63:0] d2;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [63:0] imm);
    exp_t e;
    chk("issue_ready", 64'(issue_ready_o), 64'd1);
    chk("issue_tid", 64'(issue_trans_id_o), 64'(m_tail));
    issue_valid_i        = 1'b1;
    issue_instr_i        = '0;
    issue_instr_i.rd     = rd;
    issue_instr_i.result = imm;
    tick();
    issue_valid_i = 1'b0;
    e.tid = m_tail; e.rd = rd;
    sbq.push_back(e);
    m_tail = m_tail + 3'd1;
  endtask

  task automatic do_wb(input int port, input logic [2:0] id, input logic [63:0] d);
    wb_valid_i[port]    = 1'b1;
    wb_trans_id_i[port] = id;
    wb_result_i[port]   = d;
    tick();
    wb_valid_i = '0;
    exp_res[id] = d;
  endtask

  task automatic do_commit();
    exp_t e;
    chk("commit_valid", 64'(commit_valid_o), 64'd1);
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL commit_order actual=extra_commit required=empty");
    end else begin
      e = sbq.pop_front();
      chk("commit_tid", 64'(commit_instr_o.trans_id), 64'(e.tid));
      chk("commit_rd", 64'(commit_instr_o.rd), 64'(e.rd));
      chk("commit_result", commit_instr_o.result, exp_res[e.tid]);
    end
    commit_ack_i = 1'b1;
    tick();
    commit_ack_i = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd7, 64'h70, 1'b0, 3'd0, 64'h0,  5'd5, 5'd7, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h70};
    tbl[1] = '{1'b1, 5'd5, 64'h51, 1'b0, 3'd0, 64'h0,  5'd5, 5'd0, 1'b1, 1'b0, 64'h51, 1'b0, 1'b0, 64'h0};
    tbl[2] = '{1'b1, 5'd9, 64'h90, 1'b0, 3'd0, 64'h0,  5'd5, 5'd9, 1'b1, 1'b0, 64'h51, 1'b1, 1'b0, 64'h90};
    tbl[3] = '{1'b1, 5'd3, 64'h30, 1'b1, 3'd0, 64'h77, 5'd5, 5'd7, 1'b1, 1'b0, 64'h51, 1'b1, 1'b1, 64'h77};
    tbl[4] = '{1'b1, 5'd5, 64'h54, 1'b0, 3'd0, 64'h0,  5'd5, 5'd3, 1'b1, 1'b0, 64'h54, 1'b1, 1'b0, 64'h30};
    tbl[5] = '{1'b0, 5'd0, 64'h0,  1'b1, 3'd1, 64'h15, 5'd5, 5'd0, 1'b1, 1'b0, 64'h54, 1'b0, 1'b0, 64'h0};
    tbl[6] = '{1'b0, 5'd0, 64'h0,  1'b1, 3'd4, 64'h55, 5'd5, 5'd0, 1'b1, 1'b1, 64'h55, 1'b0, 1'b0, 64'h0};
    tbl[7] = '{1'b0, 5'd0, 64'h0,  1'b0, 3'd0, 64'h0,  5'd0, 5'd5, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 64'h55};
    tbl[8] = '{1'b0, 5'd0, 64'h0,  1'b0, 3'd0, 64'h0,  5'd1, 5'd9, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h90};

    rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; issue_instr_i = '0;
    wb_valid_i = '0; wb_trans_id_i = '0; wb_result_i = '0; wb_ex_i = '0;
    commit_ack_i = 1'b0; rs1_i = 5'd0; rs2_i = 5'd0; m_tail = 3'd0;
    for (int i = 0; i < 8; i++) exp_res[i] = '0;

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 64'(issue_ready_o), 64'd1);
    chk("rst_commit_valid", 64'(commit_valid_o), 64'd0);
    chk("rst_tid", 64'(issue_trans_id_o), 64'd0);
    rst_i = 1'b0;
    tick();
    rs1_i = 5'd1; rs2_i = 5'd2;
    #1;
    chk("rst_rs1_pending", 64'(rs1_pending_o), 64'd0);
    chk("rst_rs2_pending", 64'(rs2_pending_o), 64'd0);

    // fill all 8 slots, rd = 1..8
    for (int i = 1; i <= 8; i++) do_issue(5'(i), 64'h0);
    chk("full_ready", 64'(issue_ready_o), 64'd0);
    chk("full_tid", 64'(issue_trans_id_o), 64'd0);
    issue_valid_i = 1'b1; issue_instr_i = '0; issue_instr_i.rd = 5'd9;
    tick();
    issue_valid_i = 1'b0;
    chk("ninth_rejected_ready", 64'(issue_ready_o), 64'd0);
    chk("ninth_rejected_tid", 64'(issue_trans_id_o), 64'd0);

    // out-of-order write-back, in-order commit
    do_wb(0, 3'd3, 64'h33);
    chk("wb3_no_commit", 64'(commit_valid_o), 64'd0);
    do_wb(2, 3'd0, 64'h11);
    do_commit();
    chk("after_commit_ready", 64'(issue_ready_o), 64'd1);
    chk("id1_not_done", 64'(commit_valid_o), 64'd0);
    // ports 0 and 3 both hit id 2: port 3 must win
    wb_valid_i = 4'b1011;
    wb_trans_id_i[0] = 3'd2; wb_result_i[0] = 64'hAA;
    wb_trans_id_i[1] = 3'd1; wb_result_i[1] = 64'h22;
    wb_trans_id_i[3] = 3'd2; wb_result_i[3] = 64'hBB;
    tick();
    wb_valid_i = '0;
    exp_res[1] = 64'h22; exp_res[2] = 64'hBB;
    repeat (3) do_commit();
    chk("id4_not_done", 64'(commit_valid_o), 64'd0);

    // flush with issue, write-back and ack in the same cycle
    do_wb(1, 3'd4, 64'h44);
    rs1_i = 5'd5; rs2_i = 5'd6;
    #1;
    chk("pre_flush_rs1_pending", 64'(rs1_pending_o), 64'd1);
    chk("pre_flush_rs1_data", rs1_o, 64'h44);
    flush_i = 1'b1; issue_valid_i = 1'b1; issue_instr_i = '0; issue_instr_i.rd = 5'd20;
    wb_valid_i = 4'b0001; wb_trans_id_i[0] = 3'd5; wb_result_i[0] = 64'h66;
    commit_ack_i = 1'b1;
    tick();
    flush_i = 1'b0; issue_valid_i = 1'b0; wb_valid_i = '0; commit_ack_i = 1'b0;
    sbq.delete(); m_tail = 3'd0;
    chk("flush_ready", 64'(issue_ready_o), 64'd1);
    chk("flush_commit_valid", 64'(commit_valid_o), 64'd0);
    chk("flush_tid", 64'(issue_trans_id_o), 64'd0);
    chk("flush_rs1_pending", 64'(rs1_pending_o), 64'd0);
    chk("flush_rs2_pending", 64'(rs2_pending_o), 64'd0);

    // operand lookup vectors
    for (int r = 0; r < 9; r++) begin
      issue_valid_i = tbl[r].iv;
      issue_instr_i = '0;
      issue_instr_i.rd = tbl[r].rd;
      issue_instr_i.result = tbl[r].imm;
      wb_valid_i = {3'b000, tbl[r].wv};
      wb_trans_id_i[0] = tbl[r].wid;
      wb_result_i[0] = tbl[r].wd;
      rs1_i = tbl[r].rs1; rs2_i = tbl[r].rs2;
      tick();
      issue_valid_i = 1'b0; wb_valid_i = '0;
      chk($sformatf("lk%0d_rs1_pending", r), 64'(rs1_pending_o), 64'(tbl[r].p1));
      chk($sformatf("lk%0d_rs1_valid", r), 64'(rs1_valid_o), 64'(tbl[r].v1));
      chk($sformatf("lk%0d_rs1_data", r), rs1_o, tbl[r].d1);
      chk($sformatf("lk%0d_rs2_pending", r), 64'(rs2_pending_o), 64'(tbl[r].p2));
      chk($sformatf("lk%0d_rs2_valid", r), 64'(rs2_valid_o), 64'(tbl[r].v2));
      chk($sformatf("lk%0d_rs2_data", r), rs2_o, tbl[r].d2);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    sbq.delete(); m_tail = 3'd0;

    // wrap-around: fill, retire 3, reuse ids 0..2
    for (int i = 0; i < 8; i++) do_issue(5'(10 + i), 64'h0);
    for (int c = 0; c < 2; c++) begin
      wb_valid_i = 4'b1111;
      for (int k = 0; k < 4; k++) begin
        wb_trans_id_i[k] = 3'(c * 4 + k);
        wb_result_i[k] = 64'(256 + c * 4 + k);
        exp_res[c * 4 + k] = 64'(256 + c * 4 + k);
      end
      tick();
      wb_valid_i = '0;
    end
    repeat (3) do_commit();
    for (int i = 0; i < 3; i++) do_issue(5'(20 + i), 64'h0);
    chk("wrap_full_ready", 64'(issue_ready_o), 64'd0);
    chk("wrap_head_tid", 64'(commit_instr_o.trans_id), 64'd3);
    chk("wrap_tail", 64'(issue_trans_id_o), 64'd3);
    for (int i = 0; i < 3; i++) do_wb(i, 3'(i), 64'(512 + i));
    for (int n = 0; n < 8 && sbq.size() != 0; n++) do_commit();
    chk("drain_queue_empty", 64'(sbq.size()), 64'd0);
    chk("drain_commit_valid", 64'(commit_valid_o), 64'd0);
    chk("drain_ready", 64'(issue_ready_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
